// File: rtl/pb_program_loader.sv
// Serial program loader for the KCPSM3 program ROM: parses framed UART bytes into
// 18-bit instructions, writes them through the ROM load port and holds the core in reset.
module pb_program_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  HEADER_BYTE    = 8'h5A
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic [9:0]  LOAD_ADDRESS,
  output logic [17:0] LOAD_INSTRUCTION,
  output logic        LOAD_WE,
  output logic        PB_RESET,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_H, S_CNT_L, S_B0, S_B1, S_B2, S_CKSUM, S_DONE, S_ERR
  } state_t;

  state_t        state_q;
  logic [7:0]    sum_q;
  logic [10:0]   word_q;
  logic [9:0]    last_q;
  logic [1:0]    cnt_h_q;
  logic [7:0]    b0_q;
  logic [7:0]    b1_q;
  logic [TW-1:0] tmo_q;
  logic [9:0]    load_addr_q;
  logic [17:0]   load_instr_q;
  logic          load_we_q;
  logic          pb_reset_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;

  logic [7:0]  sum_d;
  logic [17:0] instr_d;
  logic        last_word_s;
  logic        timing_s;
  logic        tmo_hit_s;

  // Running checksum, instruction assembly and timeout detection
  always_comb begin
    sum_d       = sum_q + RX_DATA;
    instr_d     = {b0_q[1:0], b1_q, RX_DATA};
    last_word_s = (word_q == {1'b0, last_q});
    timing_s    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    tmo_hit_s   = timing_s && !RX_VALID && (tmo_q == TMO_LAST);
  end

  // Frame parser FSM with all outputs registered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      sum_q        <= 8'h00;
      word_q       <= 11'd0;
      last_q       <= 10'd0;
      cnt_h_q      <= 2'd0;
      b0_q         <= 8'h00;
      b1_q         <= 8'h00;
      tmo_q        <= '0;
      load_addr_q  <= 10'd0;
      load_instr_q <= 18'd0;
      load_we_q    <= 1'b0;
      pb_reset_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      load_we_q <= 1'b0;
      done_q    <= 1'b0;
      // A byte arriving on the limit cycle wins over the timeout
      if (RX_VALID || !timing_s) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end

      if (tmo_hit_s) begin
        state_q <= S_ERR;
        error_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (RX_VALID && (RX_DATA == HEADER_BYTE)) begin
              state_q    <= S_CNT_H;
              error_q    <= 1'b0;
              busy_q     <= 1'b1;
              pb_reset_q <= 1'b1;
              sum_q      <= 8'h00;
              word_q     <= 11'd0;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_CNT_H: begin
            if (RX_VALID) begin
              if (RX_DATA[7:2] != 6'd0) begin
                state_q <= S_ERR;
                error_q <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                cnt_h_q <= RX_DATA[1:0];
                sum_q   <= sum_d;
                state_q <= S_CNT_L;
              end
            end else begin
              state_q <= S_CNT_H;
            end
          end
          S_CNT_L: begin
            if (RX_VALID) begin
              last_q  <= {cnt_h_q, RX_DATA};
              sum_q   <= sum_d;
              state_q <= S_B0;
            end else begin
              state_q <= S_CNT_L;
            end
          end
          S_B0: begin
            if (RX_VALID) begin
              b0_q    <= RX_DATA;
              sum_q   <= sum_d;
              state_q <= S_B1;
            end else begin
              state_q <= S_B0;
            end
          end
          S_B1: begin
            if (RX_VALID) begin
              b1_q    <= RX_DATA;
              sum_q   <= sum_d;
              state_q <= S_B2;
            end else begin
              state_q <= S_B1;
            end
          end
          S_B2: begin
            if (RX_VALID) begin
              load_addr_q  <= word_q[9:0];
              load_instr_q <= instr_d;
              load_we_q    <= 1'b1;
              sum_q        <= sum_d;
              word_q       <= word_q + 11'd1;
              state_q      <= last_word_s ? S_CKSUM : S_B0;
            end else begin
              state_q <= S_B2;
            end
          end
          S_CKSUM: begin
            if (RX_VALID) begin
              busy_q <= 1'b0;
              if (sum_d == 8'h00) begin
                state_q    <= S_DONE;
                done_q     <= 1'b1;
                pb_reset_q <= 1'b0;
              end else begin
                state_q <= S_ERR;
                error_q <= 1'b1;
              end
            end else begin
              state_q <= S_CKSUM;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          S_ERR:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign LOAD_ADDRESS     = load_addr_q;
  assign LOAD_INSTRUCTION = load_instr_q;
  assign LOAD_WE          = load_we_q;
  assign PB_RESET         = pb_reset_q;
  assign BUSY             = busy_q;
  assign DONE             = done_q;
  assign ERROR            = error_q;

endmodule

// File: tb/tb_pb_program_loader.sv
// Scoreboard bench for pb_program_loader: expected ROM writes are queued as frames are
// driven and compared whenever LOAD_WE fires.
module tb_pb_program_loader;

  localparam int unsigned TMO = 16;
  localparam logic [7:0]  HDR = 8'h5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [9:0]  load_address;
  logic [17:0] load_instruction;
  logic        load_we;
  logic        pb_reset;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [27:0] sb_q[$];
  logic [23:0] fixed_w [2] = '{24'h031234, 24'h00ABCD};

  pb_program_loader #(.TIMEOUT_CYCLES(TMO), .HEADER_BYTE(HDR)) dut (
    .CLK(clk), .RESET(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .LOAD_ADDRESS(load_address), .LOAD_INSTRUCTION(load_instruction),
    .LOAD_WE(load_we), .PB_RESET(pb_reset), .BUSY(busy), .DONE(done), .ERROR(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop and compare an expected write whenever the ROM port is written
  always @(negedge clk) begin
    if (load_we === 1'b1) begin
      logic [27:0] e;
      we_cnt++;
      check("we_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("we_addr", 32'(load_address), 32'(e[27:18]));
        check("we_instr", 32'(load_instruction), 32'(e[17:0]));
      end
    end
  end

  // Present one byte for one cycle; returns #1 after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: random words, 1: fixed table, 2: header byte embedded as data
  task automatic send_frame(input int n, input bit bad, input int mode);
    logic [9:0]  m;
    logic [7:0]  ch, cl, sum, b0, b1, b2, ck;
    logic [23:0] w;
    m  = 10'(n - 1);
    ch = {6'd0, m[9:8]};
    cl = m[7:0];
    send_byte(HDR);
    check("busy_after_hdr", 32'(busy), 32'd1);
    check("pbrst_after_hdr", 32'(pb_reset), 32'd1);
    check("err_clr_by_hdr", 32'(error), 32'd0);
    send_byte(ch);
    send_byte(cl);
    sum = ch + cl;
    for (int i = 0; i < n; i++) begin
      w = 24'($urandom);
      if (mode == 1) w = fixed_w[i % 2];
      if (mode == 2 && i == 0) w = {HDR, HDR, w[7:0]};
      b0 = w[23:16];
      b1 = w[15:8];
      b2 = w[7:0];
      sb_q.push_back({10'(i), b0[1:0], b1, b2});
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      sum = sum + b0 + b1 + b2;
    end
    ck = 8'h00 - sum;
    if (bad) ck = ck + 8'h01;
    send_byte(ck);
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_pbrst"}, 32'(pb_reset), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(error), 32'd0);
    idle(1);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    idle(3);
    check("rst_addr", 32'(load_address), 32'd0);
    check("rst_instr", 32'(load_instruction), 32'd0);
    check("rst_we", 32'(load_we), 32'd0);
    check("rst_pbrst", 32'(pb_reset), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    rst = 1'b0;
    idle(2);

    // Non-header bytes in idle are ignored
    send_byte(8'h11);
    check("idle_ignore", 32'(busy), 32'd0);

    // Good 2-word frame from the fixed table
    base = we_cnt;
    send_frame(2, 1'b0, 1);
    expect_done("good2");
    check("good2_writes", 32'(we_cnt - base), 32'd2);

    // Same frame with a corrupted checksum
    base = we_cnt;
    send_frame(2, 1'b1, 1);
    check("badck_err", 32'(error), 32'd1);
    check("badck_pbrst", 32'(pb_reset), 32'd1);
    check("badck_done", 32'(done), 32'd0);
    check("badck_busy", 32'(busy), 32'd0);
    idle(1);
    check("badck_writes", 32'(we_cnt - base), 32'd2);

    // Illegal high count bits abort at once
    base = we_cnt;
    send_byte(HDR);
    send_byte(8'h04);
    check("cnth_err", 32'(error), 32'd1);
    check("cnth_busy", 32'(busy), 32'd0);
    idle(2);
    check("cnth_no_we", 32'(we_cnt - base), 32'd0);

    // Header byte inside the payload is plain data
    send_frame(3, 1'b0, 2);
    expect_done("hdr_data");

    // Stall after B1 until the timeout fires
    send_byte(HDR);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (error === 1'b1) begin
        k = i;
        break;
      end
    end
    check("tmo_cycles", 32'(k), 32'(TMO));
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_pbrst", 32'(pb_reset), 32'd1);
    idle(1);
    send_frame(1, 1'b0, 0);
    expect_done("after_tmo");

    // Synchronous reset between B1 and B2
    send_byte(HDR);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h44);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_addr", 32'(load_address), 32'd0);
    check("mrst_instr", 32'(load_instruction), 32'd0);
    check("mrst_we", 32'(load_we), 32'd0);
    check("mrst_pbrst", 32'(pb_reset), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_err", 32'(error), 32'd0);
    idle(2);
    send_frame(1, 1'b0, 0);
    expect_done("after_mrst");

    // Full 1024-word frame, bytes back-to-back
    base = we_cnt;
    send_frame(1024, 1'b0, 0);
    expect_done("full");
    check("full_writes", 32'(we_cnt - base), 32'd1024);

    idle(3);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
